nv_nvdla_sdp_bn_operand_join: RTL
=================================

Name: nv_nvdla_sdp_bn_operand_join

Overview:
- Sits directly downstream of the SDP normalization read DMA. Consumes its two operand streams, ALU (nrdma2dp_alu) and MUL (nrdma2dp_mul).
- Per layer, selects which streams are used. Buffers each stream in a 2-entry skid FIFO and joins matching beats into one 513-bit operand beat for the BN datapath.
- Flags the layer end and reports a last-flag mismatch between the two streams.

Parameters:
- FIFO_DEPTH, 2, entries per input skid FIFO (fixed 2; the value is only checked, never swept).
- DW, 256, operand data width per stream.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  asynchronous, active-low reset
- op_load  in  1  single-cycle layer start; latches reg2dp_nrdma_data_use
- reg2dp_nrdma_data_use  in  2  0=MUL only, 1=ALU only, 2/3=BOTH
- nrdma2dp_alu_valid  in  1  ALU beat valid
- nrdma2dp_alu_ready  out  1  ALU beat accept
- nrdma2dp_alu_pd  in  257  [255:0] operands, [256] last-of-layer
- nrdma2dp_mul_valid  in  1  MUL beat valid
- nrdma2dp_mul_ready  out  1  MUL beat accept
- nrdma2dp_mul_pd  in  257  same format as ALU
- bn_op_valid  out  1  joined beat valid
- bn_op_ready  in  1  downstream accept
- bn_op_pd  out  513  [255:0] ALU data, [511:256] MUL data, [512] last
- bn_done  out  1  one-cycle pulse after the last beat handshakes
- bn_err_mismatch  out  1  sticky; ALU/MUL last flags differed on a joined beat

Behaviour:
- Reset: FSM=IDLE, FIFOs empty, output register empty, mode=BOTH. All outputs 0, including bn_op_pd.
- FSM states and transitions:
  - IDLE→RUN on op_load, which latches the mode. op_load in RUN or DONE is ignored.
  - RUN→DONE on a bn_op handshake with bn_op_pd[512]=1.
  - DONE→IDLE unconditionally; bn_done=1 only in DONE.
- Per-input closed flag:
  - Cleared on op_load.
  - Set when a beat with last=1 is accepted on that input.
- Input ready:
  - x_ready = RUN & stream used & !closed_x & FIFO_x not full. Not registered on input.
  - An unused stream has ready=0 for the whole layer.
- FIFO: 2 entries, registered. Push and pop in the same cycle while full is allowed; occupancy is unchanged.
- Join condition:
  - every used FIFO is non-empty, and
  - the output register is empty or handshaking this cycle.
  - When met, pop all used FIFOs together and load the output register.
- Unused-stream field: driven to zero.
- Last bit:
  - single-stream modes: last = that stream's last.
  - BOTH: last = alu_last | mul_last; if alu_last != mul_last, set bn_err_mismatch.
- bn_err_mismatch: cleared only by op_load or reset.
- Latency: input handshake in cycle N → bn_op_valid in N+2 when downstream is ready.
- Throughput: 1 beat/cycle sustained with bn_op_ready=1.
- Output stability: bn_op_valid, once high, holds with bn_op_pd stable until bn_op_ready.
- Backpressure: bn_op_ready=0 fills each FIFO to 2, then x_ready drops. No beat is lost or duplicated.
- Mismatch case (BOTH): one stream closed while the other still sends. The closed FIFO empties and no further join occurs; the layer ends only via a joined last beat.
- Reset mid-layer: all state is discarded immediately. No bn_done is issued.

Optional Feature:
- Macro: NV_NVDLA_SDP_BN_JOIN_PERF_EN.
- Defined:
  - Adds output dp2reg_bn_join_stall[31:0]: counts RUN cycles where any used x_valid=1 and x_ready=0.
  - Saturates at 0xFFFFFFFF. Cleared on op_load. Holds value in IDLE.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Mode BOTH, 4 beats per stream, alu data=i, mul data=0x100+i, last on beat 3, bn_op_ready=1 → 4 outputs, pd[255:0]=i, pd[511:256]=0x100+i, last only on beat 3, bn_done one cycle after the final handshake, bn_err_mismatch=0.
- Mode ALU only, mul_valid=1 throughout, 3 ALU beats → mul_ready stays 0, pd[511:256]=0, bn_done after beat 2.
- Mode BOTH, bn_op_ready=0 for 10 cycles with both streams valid:
  - each input takes exactly 2 beats into its FIFO and the output register holds a third (alu_ready low after 3 accepts).
  - release → all beats emerge in order, none dropped.
- Mode BOTH, alu last on beat 1, mul last on beat 2 → beat 1 last=1, bn_err_mismatch=1, bn_done. Extra MUL beat 2 is left unjoined. Next op_load clears the error.
- Reset asserted mid-layer with 1 beat buffered → all outputs 0 next cycle, no bn_done. A fresh op_load runs a clean 2-beat layer.
- With NV_NVDLA_SDP_BN_JOIN_PERF_EN: alu_valid=1 held 5 cycles while ALU FIFO full → dp2reg_bn_join_stall=5. op_load → 0.

Source files
------------

// File: rtl/nv_nvdla_sdp_bn_operand_join.sv
// SDP BN operand join: buffers the ALU/MUL normalization DMA streams and joins them into one operand beat.
// Optional macro NV_NVDLA_SDP_BN_JOIN_PERF_EN adds the dp2reg_bn_join_stall counter.

module nv_nvdla_sdp_bn_join_fifo #(
  parameter int W = 257
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) wp_q <= ~wp_q;
      if (pop_i)  rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Data slots need no reset; they are only read while occupied.
  always_ff @(posedge nvdla_core_clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = cnt_q[1];
endmodule

module nv_nvdla_sdp_bn_operand_join #(
  parameter int FIFO_DEPTH = 2,
  parameter int DW         = 256
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rstn,
  input  logic            op_load,
  input  logic [1:0]      reg2dp_nrdma_data_use,
  input  logic            nrdma2dp_alu_valid,
  output logic            nrdma2dp_alu_ready,
  input  logic [DW:0]     nrdma2dp_alu_pd,
  input  logic            nrdma2dp_mul_valid,
  output logic            nrdma2dp_mul_ready,
  input  logic [DW:0]     nrdma2dp_mul_pd,
  output logic            bn_op_valid,
  input  logic            bn_op_ready,
  output logic [2*DW:0]   bn_op_pd,
  output logic            bn_done,
  output logic            bn_err_mismatch
`ifdef NV_NVDLA_SDP_BN_JOIN_PERF_EN
  ,
  output logic [31:0]     dp2reg_bn_join_stall
`endif
);
  generate
    if (FIFO_DEPTH != 2) begin : g_bad_depth
      $error("nv_nvdla_sdp_bn_operand_join: FIFO_DEPTH must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic          alu_closed_q, alu_closed_d, mul_closed_q, mul_closed_d;
  logic          out_vld_q, out_vld_d;
  logic [2*DW:0] out_pd_q, out_pd_d;
  logic          err_q, err_d;

  logic          load_go, run, alu_used, mul_used;
  logic          alu_push, mul_push, alu_pop, mul_pop, join_go, out_hs;
  logic          alu_empty, alu_full, mul_empty, mul_full;
  logic [DW:0]   alu_dout, mul_dout;
  logic          alu_last, mul_last, join_last;

  assign load_go  = op_load & (state_q == ST_IDLE);
  assign run      = (state_q == ST_RUN);
  assign alu_used = (mode_q != 2'd0);
  assign mul_used = (mode_q != 2'd1);

  assign nrdma2dp_alu_ready = run & alu_used & ~alu_closed_q & ~alu_full;
  assign nrdma2dp_mul_ready = run & mul_used & ~mul_closed_q & ~mul_full;
  assign alu_push = nrdma2dp_alu_valid & nrdma2dp_alu_ready;
  assign mul_push = nrdma2dp_mul_valid & nrdma2dp_mul_ready;

  assign out_hs  = out_vld_q & bn_op_ready;
  assign join_go = run & (~alu_used | ~alu_empty) & (~mul_used | ~mul_empty)
                 & (~out_vld_q | bn_op_ready);
  assign alu_pop = join_go & alu_used;
  assign mul_pop = join_go & mul_used;

  assign alu_last  = alu_dout[DW];
  assign mul_last  = mul_dout[DW];
  assign join_last = (alu_used & alu_last) | (mul_used & mul_last);

  // Leftovers from a mismatched layer are flushed when the next layer starts.
  nv_nvdla_sdp_bn_join_fifo #(.W(DW+1)) u_alu_fifo (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .flush_i        (load_go),
    .push_i         (alu_push),
    .din_i          (nrdma2dp_alu_pd),
    .pop_i          (alu_pop),
    .dout_o         (alu_dout),
    .empty_o        (alu_empty),
    .full_o         (alu_full)
  );

  nv_nvdla_sdp_bn_join_fifo #(.W(DW+1)) u_mul_fifo (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .flush_i        (load_go),
    .push_i         (mul_push),
    .din_i          (nrdma2dp_mul_pd),
    .pop_i          (mul_pop),
    .dout_o         (mul_dout),
    .empty_o        (mul_empty),
    .full_o         (mul_full)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    alu_closed_d = alu_closed_q;
    mul_closed_d = mul_closed_q;
    out_vld_d    = out_vld_q;
    out_pd_d     = out_pd_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: if (op_load) state_d = ST_RUN;
      ST_RUN:  if (out_hs && out_pd_q[2*DW]) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load_go) begin
      mode_d       = reg2dp_nrdma_data_use;
      alu_closed_d = 1'b0;
      mul_closed_d = 1'b0;
      err_d        = 1'b0;
    end else begin
      if (alu_push && nrdma2dp_alu_pd[DW]) alu_closed_d = 1'b1;
      if (mul_push && nrdma2dp_mul_pd[DW]) mul_closed_d = 1'b1;
      if (join_go && alu_used && mul_used && (alu_last != mul_last)) err_d = 1'b1;
    end
    if (join_go) begin
      out_vld_d = 1'b1;
      out_pd_d  = {join_last,
                   mul_used ? mul_dout[DW-1:0] : {DW{1'b0}},
                   alu_used ? alu_dout[DW-1:0] : {DW{1'b0}}};
    end else if (out_hs) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= 2'd2;
      alu_closed_q <= 1'b0;
      mul_closed_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_pd_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      alu_closed_q <= alu_closed_d;
      mul_closed_q <= mul_closed_d;
      out_vld_q    <= out_vld_d;
      out_pd_q     <= out_pd_d;
      err_q        <= err_d;
    end
  end

  assign bn_op_valid     = out_vld_q;
  assign bn_op_pd        = out_pd_q;
  assign bn_done         = (state_q == ST_DONE);
  assign bn_err_mismatch = err_q;

`ifdef NV_NVDLA_SDP_BN_JOIN_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_hit;

  assign stall_hit = run & ((alu_used & nrdma2dp_alu_valid & ~nrdma2dp_alu_ready) |
                            (mul_used & nrdma2dp_mul_valid & ~nrdma2dp_mul_ready));

  always_comb begin
    stall_d = stall_q;
    if (load_go)                           stall_d = 32'd0;
    else if (stall_hit && stall_q != '1)   stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) stall_q <= 32'd0;
    else                  stall_q <= stall_d;
  end

  assign dp2reg_bn_join_stall = stall_q;
`endif
endmodule
